// File: rtl/pitch_track_seq_if.sv
// Candidate stream from the peak picker into the pitch tracker.
// Valid/ready handshake; cand_last is qualified by cand_valid.
interface pitch_track_seq_if #(
   parameter int N = 32
);
   logic [N-1:0] cand_in;
   logic         cand_valid;
   logic         cand_last;
   logic         cand_ready;

   modport master (
      output cand_in,
      output cand_valid,
      output cand_last,
      input  cand_ready
   );

   modport slave (
      input  cand_in,
      input  cand_valid,
      input  cand_last,
      output cand_ready
   );
endinterface

// File: rtl/pitch_track_seq.sv
// pitch_track_seq: sequential pitch tracker for the Codec2 2400 encoder.
// Takes Q16.16 sign-magnitude pitch candidates one at a time, compares each
// against the previous frame's pitch (xp) and picks the first candidate
// within TRACK_THRESH of it; otherwise falls back to the first candidate.
// The chosen value becomes xp for the next frame.
//
// Optional build macro PITCH_TRACK_STATS_EN adds frames_cnt / tracked_cnt
// outputs (16-bit, wrapping) counting frames and tracked frames.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; no frame in progress
// S_WAIT | ready for the next candidate
// S_SUB  | diff = cand - xp (sign-magnitude add of negated xp)
// S_CMP  | threshold test, fallback/first-hit capture, count candidate
// S_DONE | publish pitch_out/tracked, update xp, pulse done
module pitch_track_seq #(
   parameter int           N            = 32,
   parameter int           Q            = 16,
   parameter int           MAX_CAND     = 8,
   parameter logic [N-1:0] TRACK_THRESH = 32'h0000_3333,
   parameter logic [N-1:0] XP_INIT      = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   pitch_track_seq_if.slave     cand_if,
   output logic [N-1:0]         pitch_out,
   output logic                 tracked,
   output logic                 busy,
   output logic                 done
`ifdef PITCH_TRACK_STATS_EN
   ,
   output logic [15:0]          frames_cnt,
   output logic [15:0]          tracked_cnt
`endif
);

   localparam int CW = $clog2(MAX_CAND + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CAND - 1);

   // The fixed-point point position must leave room for an integer part.
   if (Q < 1 || Q > N - 2) begin : g_bad_q
      $error("pitch_track_seq: Q out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_SUB  = 3'd2,
      S_CMP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  cand_q, cand_d;
   logic          last_q, last_d;
   logic [N-1:0]  diff_q, diff_d;
   logic [N-1:0]  fb_q, fb_d;
   logic [N-1:0]  sel_q, sel_d;
   logic          hit_q, hit_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  xp_q, xp_d;
   logic [N-1:0]  pitch_q, pitch_d;
   logic          tracked_q, tracked_d;

   logic [N-1:0]  result;
   logic          near;

   // Sign-magnitude add; saturates magnitude on overflow, never yields -0.
   function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] mag_sum;
      logic [N-2:0] mag_r;
      logic         sgn_r;
      mag_sum = '0;
      if (a[N-1] == b[N-1]) begin
         mag_sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
         mag_r   = mag_sum[N-1] ? '1 : mag_sum[N-2:0];
         sgn_r   = a[N-1];
      end else if (a[N-2:0] >= b[N-2:0]) begin
         mag_r = a[N-2:0] - b[N-2:0];
         sgn_r = a[N-1];
      end else begin
         mag_r = b[N-2:0] - a[N-2:0];
         sgn_r = b[N-1];
      end
      if (mag_r == '0) begin
         sgn_r = 1'b0;
      end
      return {sgn_r, mag_r};
   endfunction

   // A candidate of -0 is stored as +0 so every later result is canonical.
   function automatic logic [N-1:0] sm_norm(input logic [N-1:0] x);
      return (x[N-2:0] == '0) ? '0 : x;
   endfunction

   assign result = hit_q ? sel_q : fb_q;
   assign near   = {1'b0, diff_q[N-2:0]} < {1'b0, TRACK_THRESH[N-2:0]};

   // During DONE the new result is shown immediately, then held in pitch_q.
   assign pitch_out = (state_q == S_DONE) ? result : pitch_q;
   assign tracked   = (state_q == S_DONE) ? hit_q  : tracked_q;

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d            = state_q;
      cand_d             = cand_q;
      last_d             = last_q;
      diff_d             = diff_q;
      fb_d               = fb_q;
      sel_d              = sel_q;
      hit_d              = hit_q;
      cnt_d              = cnt_q;
      xp_d               = xp_q;
      pitch_d            = pitch_q;
      tracked_d          = tracked_q;
      cand_if.cand_ready = 1'b0;
      busy               = 1'b0;
      done               = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT;
               cnt_d   = '0;
               hit_d   = 1'b0;
            end
         end
         S_WAIT: begin
            busy               = 1'b1;
            cand_if.cand_ready = 1'b1;
            if (cand_if.cand_valid) begin
               cand_d  = sm_norm(cand_if.cand_in);
               last_d  = cand_if.cand_last;
               state_d = S_SUB;
            end
         end
         S_SUB: begin
            busy    = 1'b1;
            diff_d  = sm_add(cand_q, {~xp_q[N-1], xp_q[N-2:0]});
            state_d = S_CMP;
         end
         S_CMP: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               fb_d = cand_q;
            end
            if (near && !hit_q) begin
               sel_d = cand_q;
               hit_d = 1'b1;
            end
            cnt_d   = cnt_q + CW'(1);
            state_d = (last_q || cnt_q == CNT_LAST) ? S_DONE : S_WAIT;
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            pitch_d   = result;
            tracked_d = hit_q;
            xp_d      = result;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cand_q    <= '0;
         last_q    <= 1'b0;
         diff_q    <= '0;
         fb_q      <= '0;
         sel_q     <= '0;
         hit_q     <= 1'b0;
         cnt_q     <= '0;
         xp_q      <= XP_INIT;
         pitch_q   <= '0;
         tracked_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cand_q    <= cand_d;
         last_q    <= last_d;
         diff_q    <= diff_d;
         fb_q      <= fb_d;
         sel_q     <= sel_d;
         hit_q     <= hit_d;
         cnt_q     <= cnt_d;
         xp_q      <= xp_d;
         pitch_q   <= pitch_d;
         tracked_q <= tracked_d;
      end
   end

`ifdef PITCH_TRACK_STATS_EN
   logic [15:0] frames_q;
   logic [15:0] trk_q;

   // Frame / tracked-frame counters, wrapping at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_q <= '0;
         trk_q    <= '0;
      end else if (state_q == S_DONE) begin
         frames_q <= frames_q + 16'd1;
         if (hit_q) begin
            trk_q <= trk_q + 16'd1;
         end
      end
   end

   assign frames_cnt  = frames_q;
   assign tracked_cnt = trk_q;
`endif

endmodule

// File: tb/tb_pitch_track_seq.sv
// Bench for pitch_track_seq: a behavioural model computes each frame's
// expected pitch/tracked/latency, pushes it to a scoreboard, and a monitor
// pops and compares on every done pulse.
module tb_pitch_track_seq;

   localparam int          N        = 32;
   localparam int          MAX_CAND = 8;
   localparam logic [31:0] THRESH   = 32'h0000_3333;
   localparam logic [31:0] XP_INIT  = 32'h0064_0000;

   typedef struct {
      logic [31:0] pitch;
      logic        trk;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] pitch_out;
   logic        tracked;
   logic        busy;
   logic        done;
`ifdef PITCH_TRACK_STATS_EN
   logic [15:0] frames_cnt;
   logic [15:0] tracked_cnt;
`endif

   pitch_track_seq_if #(.N(N)) cand_if ();

   pitch_track_seq #(
      .N(N), .Q(16), .MAX_CAND(MAX_CAND), .TRACK_THRESH(THRESH), .XP_INIT(XP_INIT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .cand_if(cand_if.slave),
      .pitch_out(pitch_out),
      .tracked(tracked),
      .busy(busy),
      .done(done)
`ifdef PITCH_TRACK_STATS_EN
      ,
      .frames_cnt(frames_cnt),
      .tracked_cnt(tracked_cnt)
`endif
   );

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          start_cyc = 0;
   int          frames_done = 0;
   int          trk_done = 0;
   exp_t        sb[$];
   logic [31:0] cand_buf[10];
   logic [31:0] model_xp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic longint sval(input logic [31:0] x);
      return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
   endfunction

   // Scoreboard side: compare every done pulse against the queued model result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            check("unexp_done", {31'b0, done}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pitch", pitch_out, e.pitch);
            check("tracked", {31'b0, tracked}, {31'b0, e.trk});
            check("latency", cyc - start_cyc, e.lat);
            frames_done++;
            if (e.trk) trk_done++;
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      cand_if.cand_valid = 1'b0;
      cand_if.cand_last  = 1'b0;
      cand_if.cand_in    = '0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_pitch", pitch_out, 32'd0);
      check("rst_tracked", {31'b0, tracked}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_ready", {31'b0, cand_if.cand_ready}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      model_xp = XP_INIT;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int n, input bit use_last, input int abort_at, input bit extra_start);
      logic [31:0] fb, sel, c, res;
      bit          hit, got, ended, aborted;
      longint      d;
      int          cons, hs, t;
      fb = '0; sel = '0; hit = 1'b0; cons = 0;
      for (int i = 0; i < n; i++) begin
         c = cand_buf[i];
         if (c[30:0] == 31'd0) c = '0;
         d = sval(c) - sval(model_xp);
         if (d < 0) d = -d;
         if (i == 0) fb = c;
         if (d < longint'(THRESH) && !hit) begin
            sel = c;
            hit = 1'b1;
         end
         cons++;
         if ((use_last && i == n - 1) || cons == MAX_CAND) break;
      end
      res = hit ? sel : fb;
      if (abort_at == 0) sb.push_back('{pitch: res, trk: hit, lat: 3 * cons});

      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      start_cyc = cyc;
      hs = 0; ended = 1'b0; aborted = 1'b0;
      for (int i = 0; i < n && !ended && !aborted; i++) begin
         cand_if.cand_in    = cand_buf[i];
         cand_if.cand_valid = 1'b1;
         cand_if.cand_last  = use_last && (i == n - 1);
         got = 1'b0;
         for (t = 0; t < 40 && !got && !ended; t++) begin
            @(negedge clk);
            if (cand_if.cand_ready) got = 1'b1;
            else if (done) ended = 1'b1;
         end
         if (got) begin
            @(posedge clk);
            #1;
            hs++;
            if (extra_start && hs == 1) begin
               start = 1'b1;
               @(posedge clk);
               #1;
               start = 1'b0;
            end
            if (hs == abort_at) begin
               rst_n = 1'b0;
               aborted = 1'b1;
            end
         end else if (!ended) begin
            check("accept_timeout", t, 32'd0);
         end
      end
      cand_if.cand_valid = 1'b0;
      cand_if.cand_last  = 1'b0;

      if (aborted) begin
         #2;
         check("abort_pitch", pitch_out, 32'd0);
         check("abort_tracked", {31'b0, tracked}, 32'd0);
         check("abort_busy", {31'b0, busy}, 32'd0);
         check("abort_ready", {31'b0, cand_if.cand_ready}, 32'd0);
         check("abort_done", {31'b0, done}, 32'd0);
         model_xp = XP_INIT;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         @(posedge clk);
         #1;
         return;
      end

      for (t = 0; t < 40 && !ended; t++) begin
         @(negedge clk);
         if (done) ended = 1'b1;
      end
      if (!ended) check("done_timeout", t, 32'd0);

      // start coincident with done must be ignored
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("handshakes", hs, cons);
      check("pitch_held", pitch_out, res);
      check("tracked_held", {31'b0, tracked}, {31'b0, hit});
      cand_if.cand_valid = 1'b1;
      cand_if.cand_in    = 32'h1234_5678;
      repeat (2) begin
         @(negedge clk);
         check("ready_idle", {31'b0, cand_if.cand_ready}, 32'd0);
      end
      cand_if.cand_valid = 1'b0;
      @(posedge clk);
      #1;
      model_xp = res;
   endtask

   task automatic one_cand(input logic [31:0] c);
      cand_buf[0] = c;
      run_frame(1, 1'b1, 0, 1'b0);
   endtask

   task automatic load_a();
      cand_buf[0] = 32'h0082_0000;
      cand_buf[1] = 32'h0064_2000;
      cand_buf[2] = 32'h0063_E666;
   endtask

   initial begin
      logic [31:0] base;
      int          n;
      bit          ul;
      model_xp = XP_INIT;
      do_reset();

      // tracked on the second candidate, third hit ignored
      load_a();
      run_frame(3, 1'b1, 0, 1'b0);

      // fallback from xp=100.0, with a stray start while busy
      do_reset();
      cand_buf[0] = 32'h0082_0000;
      cand_buf[1] = 32'h0050_0000;
      run_frame(2, 1'b1, 0, 1'b1);

      // threshold boundary around xp=1.0
      one_cand(32'h0001_0000);
      one_cand(32'h0001_3333);
      one_cand(32'h0001_0000);
      one_cand(32'h0001_3332);

      // negative values and -0 normalisation
      one_cand(32'h0000_0000);
      one_cand(32'h8000_2000);
      one_cand(32'h8000_0000);

      // MAX_CAND without cand_last
      for (int i = 0; i < 10; i++) cand_buf[i] = 32'h0010_0000 * (i + 1);
      cand_buf[5] = 32'h0000_1000;
      cand_buf[9] = 32'h0000_0100;
      run_frame(10, 1'b0, 0, 1'b0);

      // randomised frames near the running xp
      for (int f = 0; f < 6; f++) begin
         n  = $urandom_range(1, 10);
         ul = (n <= MAX_CAND) ? 1'b1 : 1'($urandom_range(0, 1));
         base = {1'b0, model_xp[30:0]};
         if (base < 32'h0001_0000) base = base + 32'h0001_0000;
         for (int i = 0; i < n; i++) begin
            cand_buf[i] = base + 32'($urandom_range(0, 32'h6000)) - 32'h3000;
            cand_buf[i][31] = ($urandom_range(0, 7) == 0) ? ~model_xp[31] : model_xp[31];
         end
         run_frame(n, ul, 0, 1'b0);
      end

      // reset during SUB of the second candidate, then a clean frame
      load_a();
      run_frame(3, 1'b1, 2, 1'b0);
      load_a();
      run_frame(3, 1'b1, 0, 1'b0);

      check("sb_empty", sb.size(), 32'd0);
`ifdef PITCH_TRACK_STATS_EN
      check("frames_cnt", {16'b0, frames_cnt}, frames_done);
      check("tracked_cnt", {16'b0, tracked_cnt}, trk_done);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
